// File: rtl/kamus_ctrl.sv
// kamus_ctrl: multi-cycle sequencer for the kamus-v RV32I core.
//
// Steps each instruction through FETCH -> DECODE -> EXECUTE -> (MEM) -> WB. Illegal
// instructions, EBREAK, ECALL and memory timeouts are diverted to a one-cycle TRAP.
// Every output is decoded from the current state, with a few qualified by inputs
// that are stable in that state.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   halt_i               park in IDLE when leaving WB/TRAP
//   imem_req_o           fetch request, held in FETCH until imem_rvalid_i
//   imem_rvalid_i        instruction word valid
//   ir_we_o              instruction register load strobe (same cycle as rvalid)
//   op_*_i               decoder classification of the held instruction
//   branch_taken_i       ALU compare result
//   dmem_req_o/we_o      data access request / store, held in MEM until dmem_rvalid_i
//   dmem_rvalid_i        data response valid
//   rf_we_o              register-file write strobe (WB)
//   pc_we_o, pc_sel_o    PC update strobe and source (0=PC+4, 1=target, 2=trap vector)
//   trap_o, trap_cause_o trap strobe and mcause code
//   retire_o, instret_o  retire strobe and retired-instruction counter
//   state_o              current state encoding
module kamus_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             halt_i,
    output logic             imem_req_o,
    input  logic             imem_rvalid_i,
    output logic             ir_we_o,
    input  logic             op_illegal_i,
    input  logic             op_ecall_i,
    input  logic             op_ebreak_i,
    input  logic             op_load_i,
    input  logic             op_store_i,
    input  logic             op_branch_i,
    input  logic             op_jump_i,
    input  logic             branch_taken_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_rvalid_i,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             trap_o,
    output logic [3:0]       trap_cause_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [2:0]       state_o
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitMax = WaitW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [3:0] CauseIfetchFault = 4'd1;
    localparam logic [3:0] CauseIllegal     = 4'd2;
    localparam logic [3:0] CauseBreak       = 4'd3;
    localparam logic [3:0] CauseLoadFault   = 4'd5;
    localparam logic [3:0] CauseStoreFault  = 4'd7;
    localparam logic [3:0] CauseEcall       = 4'd11;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcTarget = 2'd1;
    localparam logic [1:0] PcTrap   = 2'd2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StMem     = 3'd4,
        StWb      = 3'd5,
        StTrap    = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [3:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitMax);

    always_comb begin
        state_d      = state_q;
        // Counter is zero on entry to every state; only FETCH/MEM advance it.
        wait_d       = '0;
        cause_d      = cause_q;
        instret_d    = instret_q;
        imem_req_o   = 1'b0;
        ir_we_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        rf_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_sel_o     = PcPlus4;
        trap_o       = 1'b0;
        trap_cause_o = 4'd0;
        retire_o     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!halt_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                imem_req_o = 1'b1;
                if (imem_rvalid_i) begin
                    // A response in the expiry cycle still wins.
                    ir_we_o = 1'b1;
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    cause_d = CauseIfetchFault;
                    state_d = StTrap;
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                if (op_illegal_i) begin
                    cause_d = CauseIllegal;
                    state_d = StTrap;
                end else if (op_ebreak_i) begin
                    cause_d = CauseBreak;
                    state_d = StTrap;
                end else if (op_ecall_i) begin
                    cause_d = CauseEcall;
                    state_d = StTrap;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                state_d = (op_load_i || op_store_i) ? StMem : StWb;
            end
            StMem: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = op_store_i;
                if (dmem_rvalid_i) begin
                    state_d = StWb;
                end else if (timeout_hit) begin
                    cause_d = op_store_i ? CauseStoreFault : CauseLoadFault;
                    state_d = StTrap;
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWb: begin
                pc_we_o   = 1'b1;
                retire_o  = 1'b1;
                instret_d = instret_q + CNT_W'(1);
                rf_we_o   = !(op_store_i || op_branch_i);
                pc_sel_o  = (op_jump_i || (op_branch_i && branch_taken_i)) ? PcTarget : PcPlus4;
                state_d   = halt_i ? StIdle : StFetch;
            end
            StTrap: begin
                trap_o       = 1'b1;
                trap_cause_o = cause_q;
                pc_we_o      = 1'b1;
                pc_sel_o     = PcTrap;
                state_d      = halt_i ? StIdle : StFetch;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            cause_q   <= 4'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign state_o   = state_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_kamus_ctrl.sv
// Self-checking bench for kamus_ctrl. A reference model turns each instruction's
// class and memory wait times into the expected list of states, then every cycle's
// outputs are compared against the output table of the current expected state.
module tb_kamus_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 32;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             halt_i = 1'b1;
    logic             imem_rvalid_i = 1'b0;
    logic             op_illegal_i = 1'b0;
    logic             op_ecall_i = 1'b0;
    logic             op_ebreak_i = 1'b0;
    logic             op_load_i = 1'b0;
    logic             op_store_i = 1'b0;
    logic             op_branch_i = 1'b0;
    logic             op_jump_i = 1'b0;
    logic             branch_taken_i = 1'b0;
    logic             dmem_rvalid_i = 1'b0;
    logic             imem_req_o;
    logic             ir_we_o;
    logic             dmem_req_o;
    logic             dmem_we_o;
    logic             rf_we_o;
    logic             pc_we_o;
    logic [1:0]       pc_sel_o;
    logic             trap_o;
    logic [3:0]       trap_cause_o;
    logic             retire_o;
    logic [CNT_W-1:0] instret_o;
    logic [2:0]       state_o;

    kamus_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .halt_i         (halt_i),
        .imem_req_o     (imem_req_o),
        .imem_rvalid_i  (imem_rvalid_i),
        .ir_we_o        (ir_we_o),
        .op_illegal_i   (op_illegal_i),
        .op_ecall_i     (op_ecall_i),
        .op_ebreak_i    (op_ebreak_i),
        .op_load_i      (op_load_i),
        .op_store_i     (op_store_i),
        .op_branch_i    (op_branch_i),
        .op_jump_i      (op_jump_i),
        .branch_taken_i (branch_taken_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .rf_we_o        (rf_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o),
        .retire_o       (retire_o),
        .instret_o      (instret_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned      vectors = 0;
    int unsigned      miscompares = 0;
    logic [CNT_W-1:0] model_instret = '0;
    int unsigned      obs_imem_req;
    int unsigned      obs_dmem_req;
    int unsigned      obs_trap;
    int unsigned      obs_retire;

    typedef struct {
        logic [2:0] st;
        logic       irv;
        logic       drv;
    } step_t;

    function automatic logic [16:0] observed();
        return {state_o, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o,
                pc_sel_o, trap_o, trap_cause_o, retire_o};
    endfunction

    // Output table per state: {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
    // pc_sel, trap, cause, retire}.
    function automatic logic [16:0] exp_vec(input logic [2:0] st, input logic irv,
                                            input logic sr, input logic br, input logic jp,
                                            input logic tk, input logic [3:0] cause);
        logic imem, irwe, dreq, dwe, rfwe, pcwe, trap, ret;
        logic [1:0] sel;
        logic [3:0] c;
        {imem, irwe, dreq, dwe, rfwe, pcwe, trap, ret} = 8'd0;
        sel = 2'd0;
        c   = 4'd0;
        case (st)
            3'd1: begin imem = 1'b1; irwe = irv; end
            3'd4: begin dreq = 1'b1; dwe = sr; end
            3'd5: begin
                rfwe = !(sr || br);
                pcwe = 1'b1;
                sel  = (jp || (br && tk)) ? 2'd1 : 2'd0;
                ret  = 1'b1;
            end
            3'd6: begin trap = 1'b1; c = cause; pcwe = 1'b1; sel = 2'd2; end
            default: ;
        endcase
        return {st, imem, irwe, dreq, dwe, rfwe, pcwe, sel, trap, c, ret};
    endfunction

    // Runs one instruction starting in FETCH (called just after a rising edge).
    // fw/mw: cycles without response before rvalid; >= TIMEOUT means never.
    task automatic exec_instr(input logic il, input logic ec, input logic eb, input logic ld,
                              input logic sr, input logic br, input logic jp, input logic tk,
                              input int unsigned fw, input int unsigned mw,
                              input logic halt_end, input string tag);
        step_t       q[$];
        step_t       s;
        logic [3:0]  cause;
        int unsigned n;
        logic [16:0] ev;
        logic [16:0] ov;
        logic [2:0]  next_st;

        cause = 4'd0;
        s.drv = 1'b0;
        n = (fw < TIMEOUT) ? fw + 1 : TIMEOUT;
        for (int unsigned i = 0; i < n; i++) begin
            s.st  = 3'd1;
            s.irv = (fw < TIMEOUT) && (i == fw);
            q.push_back(s);
        end
        s.irv = 1'b0;
        if (fw >= TIMEOUT) begin
            cause = 4'd1;
        end else begin
            s.st = 3'd2;
            q.push_back(s);
            if (il) cause = 4'd2;
            else if (eb) cause = 4'd3;
            else if (ec) cause = 4'd11;
            if (cause == 4'd0) begin
                s.st = 3'd3;
                q.push_back(s);
                if (ld || sr) begin
                    n = (mw < TIMEOUT) ? mw + 1 : TIMEOUT;
                    for (int unsigned i = 0; i < n; i++) begin
                        s.st  = 3'd4;
                        s.drv = (mw < TIMEOUT) && (i == mw);
                        q.push_back(s);
                    end
                    if (mw >= TIMEOUT) cause = sr ? 4'd7 : 4'd5;
                end
            end
        end
        s.drv = 1'b0;
        s.st  = (cause != 4'd0) ? 3'd6 : 3'd5;
        q.push_back(s);
        if (cause == 4'd0) model_instret = model_instret + 1'b1;

        op_illegal_i   = il;
        op_ecall_i     = ec;
        op_ebreak_i    = eb;
        op_load_i      = ld;
        op_store_i     = sr;
        op_branch_i    = br;
        op_jump_i      = jp;
        branch_taken_i = tk;
        obs_imem_req = 0;
        obs_dmem_req = 0;
        obs_trap     = 0;
        obs_retire   = 0;

        foreach (q[k]) begin
            @(negedge clk_i);
            // Responses outside their own state and halt outside WB/TRAP must be ignored.
            imem_rvalid_i = (q[k].st == 3'd1) ? q[k].irv : 1'($urandom);
            dmem_rvalid_i = (q[k].st == 3'd4) ? q[k].drv : 1'($urandom);
            halt_i        = (q[k].st == 3'd5 || q[k].st == 3'd6) ? halt_end : 1'($urandom);
            #1;
            ev = exp_vec(q[k].st, q[k].irv, sr, br, jp, tk, cause);
            ov = observed();
            vectors++;
            if (ov !== ev) begin
                miscompares++;
                $display("FAIL %s step %0d: got %b required %b", tag, k, ov, ev);
            end
            if (imem_req_o) obs_imem_req++;
            if (dmem_req_o) obs_dmem_req++;
            if (trap_o) obs_trap++;
            if (retire_o) obs_retire++;
        end

        @(posedge clk_i);
        #1;
        next_st = halt_end ? 3'd0 : 3'd1;
        vectors++;
        if (state_o !== next_st || instret_o !== model_instret) begin
            miscompares++;
            $display("FAIL %s exit: state %0d instret %0d, required state %0d instret %0d",
                     tag, state_o, instret_o, next_st, model_instret);
        end
    endtask

    // Hold in IDLE for k cycles with halt, then release and expect FETCH.
    task automatic leave_idle(input int unsigned k);
        for (int unsigned i = 0; i <= k; i++) begin
            @(negedge clk_i);
            halt_i        = (i < k);
            imem_rvalid_i = 1'($urandom);
            dmem_rvalid_i = 1'($urandom);
            #1;
            vectors++;
            if (observed() !== 17'd0) begin
                miscompares++;
                $display("FAIL idle cycle %0d: got %b required all zero", i, observed());
            end
        end
        @(posedge clk_i);
        #1;
        vectors++;
        if (state_o !== 3'd1) begin
            miscompares++;
            $display("FAIL idle release: state %0d required 1", state_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        halt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            {op_illegal_i, op_ecall_i, op_ebreak_i, op_load_i} = 4'($urandom);
            {op_store_i, op_branch_i, op_jump_i, branch_taken_i} = 4'($urandom);
            imem_rvalid_i = 1'($urandom);
            dmem_rvalid_i = 1'($urandom);
            #1;
            vectors++;
            if (observed() !== 17'd0 || instret_o !== '0) begin
                miscompares++;
                $display("FAIL reset: outputs %b instret %0d required zero", observed(), instret_o);
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        vectors++;
        if (state_o !== 3'd0) begin
            miscompares++;
            $display("FAIL reset halt park: state %0d required 0", state_o);
        end
        model_instret = '0;
    endtask

    task automatic test_alu();
        leave_idle(1);
        exec_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, "alu");
        vectors++;
        if (instret_o !== 32'd1 || obs_retire != 1) begin
            miscompares++;
            $display("FAIL alu retire: instret %0d retires %0d required 1 and 1",
                     instret_o, obs_retire);
        end
    endtask

    task automatic test_load_store();
        int unsigned mw;
        exec_instr(0, 0, 0, 1, 0, 0, 0, 0, $urandom_range(0, 3), 3, 1'b0, "load");
        vectors++;
        if (obs_dmem_req != 4) begin
            miscompares++;
            $display("FAIL load dmem_req cycles: got %0d required 4", obs_dmem_req);
        end
        mw = $urandom_range(0, 5);
        exec_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, mw, 1'b0, "store");
        vectors++;
        if (obs_dmem_req != mw + 1) begin
            miscompares++;
            $display("FAIL store dmem_req cycles: got %0d required %0d", obs_dmem_req, mw + 1);
        end
    endtask

    task automatic test_branch();
        logic [CNT_W-1:0] base;
        base = model_instret;
        exec_instr(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1'b0, "branch_taken");
        exec_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1'b0, "branch_not_taken");
        exec_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1'b0, "jump");
        vectors++;
        if (instret_o !== base + 32'd3) begin
            miscompares++;
            $display("FAIL branch instret: got %0d required %0d", instret_o, base + 32'd3);
        end
    endtask

    task automatic test_traps();
        logic [CNT_W-1:0] base;
        logic [2:0]       flags [4];
        flags[0] = 3'b100;  // {illegal, ebreak, ecall}
        flags[1] = 3'b010;
        flags[2] = 3'b001;
        flags[3] = 3'b101;
        for (int i = 0; i < 4; i++) begin
            base = model_instret;
            exec_instr(flags[i][2], flags[i][0], flags[i][1], 0, 0, 0, 0, 0, 0, 0, 1'b0, "trap");
            vectors++;
            if (obs_trap != 1 || instret_o !== base) begin
                miscompares++;
                $display("FAIL trap %0d: traps %0d instret %0d required 1 and %0d",
                         i, obs_trap, instret_o, base);
            end
        end
    endtask

    task automatic test_timeout();
        exec_instr(0, 0, 0, 0, 0, 0, 0, 0, TIMEOUT + 2, 0, 1'b0, "ifetch_timeout");
        vectors++;
        if (obs_imem_req != TIMEOUT || obs_trap != 1) begin
            miscompares++;
            $display("FAIL ifetch timeout: req cycles %0d traps %0d required %0d and 1",
                     obs_imem_req, obs_trap, TIMEOUT);
        end
        exec_instr(0, 0, 0, 0, 0, 0, 0, 0, TIMEOUT - 1, 0, 1'b0, "ifetch_last_cycle");
        vectors++;
        if (obs_imem_req != TIMEOUT || obs_trap != 0) begin
            miscompares++;
            $display("FAIL ifetch last-cycle rvalid: req cycles %0d traps %0d required %0d and 0",
                     obs_imem_req, obs_trap, TIMEOUT);
        end
        exec_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, 40, 1'b0, "load_timeout");
        exec_instr(0, 0, 0, 0, 1, 0, 0, 0, 2, TIMEOUT, 1'b0, "store_timeout");
        vectors++;
        if (obs_dmem_req != TIMEOUT || obs_trap != 1) begin
            miscompares++;
            $display("FAIL store timeout: req cycles %0d traps %0d required %0d and 1",
                     obs_dmem_req, obs_trap, TIMEOUT);
        end
    endtask

    task automatic test_halt();
        exec_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, "halt_wb");
        vectors++;
        if (retire_o !== 1'b0 || pc_we_o !== 1'b0 || imem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL halt idle strobes: retire %b pc_we %b imem_req %b required 0",
                     retire_o, pc_we_o, imem_req_o);
        end
        leave_idle(3);
        exec_instr(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1'b1, "halt_trap");
        leave_idle(0);
    endtask

    task automatic test_random();
        logic [7:0]  f;
        int unsigned kind;
        int unsigned fw;
        int unsigned mw;
        logic        h;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 7);
            f    = 8'd0;  // {il, ec, eb, ld, sr, br, jp, tk}
            case (kind)
                0: ;
                1: f[4] = 1'b1;
                2: f[3] = 1'b1;
                3: begin f[2] = 1'b1; f[0] = 1'($urandom); end
                4: f[1] = 1'b1;
                5: f = {1'b1, 7'($urandom)};
                6: f = {1'b0, 1'($urandom), 1'b1, 5'd0};
                default: f[6] = 1'b1;
            endcase
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                             : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                             : $urandom_range(0, 3);
            h  = ($urandom_range(0, 4) == 0);
            exec_instr(f[7], f[6], f[5], f[4], f[3], f[2], f[1], f[0], fw, mw, h, "random");
            if (h) leave_idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_mem();
        op_illegal_i = 0; op_ecall_i = 0; op_ebreak_i = 0; op_store_i = 0;
        op_branch_i = 0; op_jump_i = 0; branch_taken_i = 0;
        op_load_i = 1'b1;
        halt_i    = 1'b0;
        @(negedge clk_i);
        imem_rvalid_i = 1'b1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        imem_rvalid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        vectors++;
        if (state_o !== 3'd4 || dmem_req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid-mem setup: state %0d dmem_req %b required 4 and 1",
                     state_o, dmem_req_o);
        end
        @(negedge clk_i);
        #1;
        rst_ni = 1'b0;
        halt_i = 1'b1;
        #1;
        vectors++;
        if (observed() !== 17'd0 || instret_o !== '0) begin
            miscompares++;
            $display("FAIL mid-mem reset: outputs %b instret %0d required zero",
                     observed(), instret_o);
        end
        model_instret = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        vectors++;
        if (state_o !== 3'd0 || instret_o !== model_instret) begin
            miscompares++;
            $display("FAIL after mid-mem reset: state %0d instret %0d required 0 and 0",
                     state_o, instret_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_traps();
        test_timeout();
        test_halt();
        test_random();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
